// File: rtl/ahb_ext_mem_pkg.sv
// Shared AHB definitions for the external memory subordinate: transfer and
// response encodings, the controller state type and an alignment helper.
package ahb_ext_mem_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } ext_mem_state_e;

  // Low address bits that must be zero for a transfer of 2^hsize bytes.
  function automatic logic [6:0] size_mask(input logic [2:0] hsize);
    return (7'd1 << hsize) - 7'd1;
  endfunction

endpackage

// File: rtl/ahb_ext_mem_array.sv
// Word-organised storage with a byte-strobed synchronous write port and a
// combinational read port; contents are deliberately not reset.
module ahb_ext_mem_array #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wstrb,
  input  logic [AW-1:0]      raddr,
  output logic [WIDTH-1:0]   rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < WIDTH/8; b++) begin
        if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_ext_mem.sv
// AHB subordinate fronting an on-chip word array: configurable wait states,
// two-cycle ERROR response for out-of-range, oversized or misaligned transfers.
module ahb_ext_mem #(
  parameter int          AHBW        = 64,
  parameter int          PA_BITS     = 56,
  parameter logic [63:0] BASE        = 64'h8000_0000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               HSELEXT,
  input  logic [PA_BITS-1:0] HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [2:0]         HBURST,
  input  logic [AHBW-1:0]    HWDATA,
  input  logic [AHBW/8-1:0]  HWSTRB,
  input  logic               HREADY,
  output logic [AHBW-1:0]    HRDATAEXT,
  output logic               HREADYEXT,
  output logic               HRESPEXT
);
  import ahb_ext_mem_pkg::*;

  localparam int          BYTES        = AHBW / 8;
  localparam int          BYTE_OFS     = $clog2(BYTES);
  localparam int          WORD_AW      = $clog2(DEPTH);
  localparam logic [2:0]  MAX_SIZE     = 3'(BYTE_OFS);
  localparam logic [63:0] REGION_BYTES = 64'(DEPTH) * 64'(BYTES);
  localparam logic [3:0]  WAIT_LOAD    = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  ext_mem_state_e      state_q, state_d;
  logic [3:0]          cnt_q;
  logic                pend_q;
  logic                pend_write_q;
  logic [WORD_AW-1:0]  idx_q;
  logic [AHBW-1:0]     mem_rdata;
  logic [63:0]         addr_ext;
  logic [63:0]         offset;
  logic [WORD_AW-1:0]  word_idx;
  logic                accept;
  logic                bad;
  logic                complete;
  logic                mem_we;
  logic                unused_bits;

  assign unused_bits = ^{HTRANS[0], HBURST};

  // HREADY is only high in IDLE/ERR2 of our own data phase, so accept is gated to those states.
  assign accept   = HSELEXT && HTRANS[1] && HREADY &&
                    ((state_q == ST_IDLE) || (state_q == ST_ERR2));
  assign addr_ext = 64'(HADDR);
  assign offset   = addr_ext - BASE;
  assign word_idx = WORD_AW'(offset >> BYTE_OFS);
  assign bad      = (addr_ext < BASE) || (offset >= REGION_BYTES) || (HSIZE > MAX_SIZE) ||
                    ((HADDR[6:0] & size_mask(HSIZE)) != 7'd0);
  assign complete = (state_q == ST_IDLE) && pend_q;
  assign mem_we   = complete && pend_write_q && !reset;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (!accept)               state_d = ST_IDLE;
        else if (bad)              state_d = ST_ERR1;
        else if (WAIT_STATES > 0)  state_d = ST_WAIT;
        else                       state_d = ST_IDLE;
      end
      ST_WAIT: if (cnt_q == 4'd0) state_d = ST_IDLE;
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // A bad accept never becomes pending, so errored writes cannot reach the array.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= 4'd0;
      pend_q       <= 1'b0;
      pend_write_q <= 1'b0;
      idx_q        <= '0;
    end else if (accept) begin
      cnt_q        <= WAIT_LOAD;
      pend_q       <= !bad;
      pend_write_q <= HWRITE;
      idx_q        <= word_idx;
    end else begin
      if (complete) pend_q <= 1'b0;
      if ((state_q == ST_WAIT) && (cnt_q != 4'd0)) cnt_q <= cnt_q - 4'd1;
    end
  end

  always_comb begin
    HREADYEXT = 1'b1;
    HRESPEXT  = HRESP_OKAY;
    HRDATAEXT = '0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: if (pend_q && !pend_write_q) HRDATAEXT = mem_rdata;
        ST_WAIT: HREADYEXT = 1'b0;
        ST_ERR1: begin
          HREADYEXT = 1'b0;
          HRESPEXT  = HRESP_ERROR;
        end
        ST_ERR2: HRESPEXT = HRESP_ERROR;
        default: HREADYEXT = 1'b1;
      endcase
    end
  end

  ahb_ext_mem_array #(
    .WIDTH (AHBW),
    .DEPTH (DEPTH),
    .AW    (WORD_AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (idx_q),
    .wdata (HWDATA),
    .wstrb (HWSTRB),
    .raddr (idx_q),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_ahb_ext_mem.sv
// Directed bench: three instances (0, 2 and 3 wait states) share one AHB bus;
// each step drives an address phase and checks the data-phase outputs.
module tb_ahb_ext_mem;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  hsel;
  logic [55:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [63:0] hwdata;
  logic [7:0]  hwstrb;
  logic        hready;
  logic [2:0]  hreadyext;
  logic [2:0]  hrespext;
  logic [63:0] hrdata [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Bus-level ready: any subordinate stalling its data phase stalls the bus.
  assign hready = &hreadyext;

  ahb_ext_mem #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .HSELEXT(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HWSTRB(hwstrb),
    .HREADY(hready), .HRDATAEXT(hrdata[0]), .HREADYEXT(hreadyext[0]), .HRESPEXT(hrespext[0])
  );

  ahb_ext_mem #(.WAIT_STATES(2)) u_ws2 (
    .clk(clk), .reset(reset), .HSELEXT(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HWSTRB(hwstrb),
    .HREADY(hready), .HRDATAEXT(hrdata[1]), .HREADYEXT(hreadyext[1]), .HRESPEXT(hrespext[1])
  );

  ahb_ext_mem #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset), .HSELEXT(hsel[2]), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HWSTRB(hwstrb),
    .HREADY(hready), .HRDATAEXT(hrdata[2]), .HREADYEXT(hreadyext[2]), .HRESPEXT(hrespext[2])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // sel 0..2 picks an instance; 3 deselects all of them
  task automatic applyStimulus(input int sel, input logic [1:0] trans, input logic wr,
                               input logic [55:0] addr, input logic [2:0] size);
    hsel   = (sel < 3) ? (3'b001 << sel) : 3'b000;
    htrans = trans;
    hwrite = wr;
    haddr  = addr;
    hsize  = size;
  endtask

  task automatic idleBus();
    applyStimulus(3, T_IDLE, 1'b0, 56'h0, 3'd3);
  endtask

  task automatic setData(input logic [63:0] data, input logic [7:0] strb);
    hwdata = data;
    hwstrb = strb;
  endtask

  task automatic checkOutput(input int u, input string tag, input logic exp_ready,
                             input logic exp_resp, input logic [63:0] exp_data);
    checks++;
    assert (hreadyext[u] === exp_ready) else begin
      errors++;
      $error("[TB] FAIL %s HREADYEXT observed=%0b expected=%0b", tag, hreadyext[u], exp_ready);
    end
    checks++;
    assert (hrespext[u] === exp_resp) else begin
      errors++;
      $error("[TB] FAIL %s HRESPEXT observed=%0b expected=%0b", tag, hrespext[u], exp_resp);
    end
    checks++;
    assert (hrdata[u] === exp_data) else begin
      errors++;
      $error("[TB] FAIL %s HRDATAEXT observed=%h expected=%h", tag, hrdata[u], exp_data);
    end
  endtask

  initial begin
    reset  = 1'b1;
    hburst = 3'b000;
    idleBus();
    setData(64'h0, 8'h00);
    step();
    step();
    checkOutput(0, "reset_ws0", 1'b1, 1'b0, 64'h0);
    checkOutput(2, "reset_ws3", 1'b1, 1'b0, 64'h0);

    // Zero-wait instance: pipelined writes followed by a read of the last written word
    reset = 1'b0;
    applyStimulus(0, T_NONSEQ, 1'b1, 56'h8000_0010, 3'd3);
    step();
    checkOutput(0, "wr_dataphase", 1'b1, 1'b0, 64'h0);
    setData(64'h0, 8'hFF);
    applyStimulus(0, T_NONSEQ, 1'b1, 56'h8000_0000, 3'd3);
    step();
    setData(64'hA5A5_A5A5_A5A5_A5A5, 8'hFF);
    applyStimulus(0, T_NONSEQ, 1'b1, 56'h8000_0008, 3'd3);
    step();
    setData(64'h1122_3344_5566_7788, 8'hFF);
    applyStimulus(0, T_NONSEQ, 1'b0, 56'h8000_0008, 3'd3);
    step();
    checkOutput(0, "b2b_read", 1'b1, 1'b0, 64'h1122_3344_5566_7788);
    idleBus();
    step();
    checkOutput(0, "idle_zero", 1'b1, 1'b0, 64'h0);

    // Partial strobe updates only the low four bytes
    applyStimulus(0, T_NONSEQ, 1'b1, 56'h8000_0010, 3'd3);
    step();
    setData(64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    applyStimulus(0, T_NONSEQ, 1'b0, 56'h8000_0010, 3'd3);
    step();
    checkOutput(0, "strobe_read", 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF);
    idleBus();
    step();

    // One past the end of the region: two-cycle error response
    applyStimulus(0, T_NONSEQ, 1'b0, 56'h8000_2000, 3'd3);
    step();
    idleBus();
    checkOutput(0, "oob_err1", 1'b0, 1'b1, 64'h0);
    step();
    checkOutput(0, "oob_err2", 1'b1, 1'b1, 64'h0);
    step();
    checkOutput(0, "oob_okay", 1'b1, 1'b0, 64'h0);

    // Errored write would alias word 0 if it leaked into the array
    applyStimulus(0, T_NONSEQ, 1'b1, 56'h8000_2000, 3'd3);
    step();
    setData(64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
    idleBus();
    checkOutput(0, "oob_wr_err1", 1'b0, 1'b1, 64'h0);
    step();
    checkOutput(0, "oob_wr_err2", 1'b1, 1'b1, 64'h0);
    step();
    applyStimulus(0, T_NONSEQ, 1'b0, 56'h8000_0000, 3'd3);
    step();
    checkOutput(0, "oob_wr_nomod", 1'b1, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5);
    idleBus();
    step();

    // Misaligned word-sized and oversized transfers
    applyStimulus(0, T_NONSEQ, 1'b0, 56'h8000_0002, 3'd2);
    step();
    idleBus();
    checkOutput(0, "misaligned", 1'b0, 1'b1, 64'h0);
    step();
    step();
    applyStimulus(0, T_NONSEQ, 1'b0, 56'h8000_0000, 3'd4);
    step();
    idleBus();
    checkOutput(0, "oversize", 1'b0, 1'b1, 64'h0);
    step();
    step();

    // BUSY and deselected writes must not touch the array
    applyStimulus(0, T_BUSY, 1'b1, 56'h8000_0000, 3'd3);
    step();
    setData(64'h0, 8'hFF);
    checkOutput(0, "busy_okay", 1'b1, 1'b0, 64'h0);
    applyStimulus(3, T_NONSEQ, 1'b1, 56'h8000_0000, 3'd3);
    step();
    checkOutput(0, "unsel_okay", 1'b1, 1'b0, 64'h0);
    applyStimulus(0, T_NONSEQ, 1'b0, 56'h8000_0000, 3'd3);
    step();
    checkOutput(0, "busy_nomod", 1'b1, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5);
    idleBus();
    step();

    // Two wait states: write then back-to-back read of the same word
    applyStimulus(1, T_NONSEQ, 1'b1, 56'h8000_0000, 3'd3);
    step();
    setData(64'h0123_4567_89AB_CDEF, 8'hFF);
    idleBus();
    checkOutput(1, "ws2_wr_w1", 1'b0, 1'b0, 64'h0);
    step();
    checkOutput(1, "ws2_wr_w2", 1'b0, 1'b0, 64'h0);
    step();
    checkOutput(1, "ws2_wr_done", 1'b1, 1'b0, 64'h0);
    applyStimulus(1, T_NONSEQ, 1'b0, 56'h8000_0000, 3'd3);
    step();
    idleBus();
    checkOutput(1, "ws2_rd_w1", 1'b0, 1'b0, 64'h0);
    step();
    checkOutput(1, "ws2_rd_w2", 1'b0, 1'b0, 64'h0);
    step();
    checkOutput(1, "ws2_rd_done", 1'b1, 1'b0, 64'h0123_4567_89AB_CDEF);
    step();
    checkOutput(1, "ws2_after", 1'b1, 1'b0, 64'h0);

    // Three wait states: baseline write, then a write aborted by reset
    applyStimulus(2, T_NONSEQ, 1'b1, 56'h8000_0018, 3'd3);
    step();
    setData(64'h5555_5555_5555_5555, 8'hFF);
    idleBus();
    checkOutput(2, "ws3_wr_w1", 1'b0, 1'b0, 64'h0);
    step();
    step();
    step();
    checkOutput(2, "ws3_wr_done", 1'b1, 1'b0, 64'h0);
    step();
    applyStimulus(2, T_NONSEQ, 1'b1, 56'h8000_0018, 3'd3);
    step();
    setData(64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
    idleBus();
    checkOutput(2, "ws3_abort_w1", 1'b0, 1'b0, 64'h0);
    step();
    checkOutput(2, "ws3_abort_w2", 1'b0, 1'b0, 64'h0);
    reset = 1'b1;
    step();
    checkOutput(2, "ws3_reset", 1'b1, 1'b0, 64'h0);
    reset = 1'b0;
    step();
    checkOutput(2, "ws3_post_reset", 1'b1, 1'b0, 64'h0);
    applyStimulus(2, T_NONSEQ, 1'b0, 56'h8000_0018, 3'd3);
    step();
    idleBus();
    checkOutput(2, "ws3_rd_w1", 1'b0, 1'b0, 64'h0);
    step();
    checkOutput(2, "ws3_rd_w2", 1'b0, 1'b0, 64'h0);
    step();
    checkOutput(2, "ws3_rd_w3", 1'b0, 1'b0, 64'h0);
    step();
    checkOutput(2, "ws3_old_data", 1'b1, 1'b0, 64'h5555_5555_5555_5555);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
